// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle fill engine.
// Holds the fill FSM states, clip result bundle and sizing defaults.
package draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIP,
    S_LINE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } fill_state_t;

  localparam int BURST_MAX_DEF = 256;
  localparam int BOUNDARY_DEF  = 4096;
  localparam int PIX_BYTES     = 4;

  typedef struct packed {
    logic        empty;
    logic [12:0] x0;
    logic [12:0] x1;
    logic [12:0] y0;
    logic [12:0] y1;
  } clip_t;

endpackage

// File: rtl/draw_fill_clip.sv
// Intersects the destination rectangle with the clip area.
// Result is registered when a command is accepted.
module draw_fill_clip
  import draw_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [43:0] area,
  input  logic [23:0] dpos,
  input  logic [21:0] dsiz,
  output clip_t       clip
);

  logic signed [12:0] dx, dy, ax, ay;
  logic signed [12:0] dxe, dye, axe, aye;
  logic signed [12:0] x0, x1, y0, y1;

  // 13-bit signed edges of both rectangles and their overlap
  always_comb begin
    dx  = signed'({dpos[23], dpos[23:12]});
    dy  = signed'({dpos[11], dpos[11:0]});
    ax  = signed'({2'b00, area[43:33]});
    ay  = signed'({2'b00, area[32:22]});
    dxe = dx + signed'({2'b00, dsiz[21:11]});
    dye = dy + signed'({2'b00, dsiz[10:0]});
    axe = ax + signed'({2'b00, area[21:11]});
    aye = ay + signed'({2'b00, area[10:0]});
    x0  = (dx > ax) ? dx : ax;
    y0  = (dy > ay) ? dy : ay;
    x1  = (dxe < axe) ? dxe : axe;
    y1  = (dye < aye) ? dye : aye;
  end

  // capture the clipped window on command acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      clip <= '0;
    end else if (en) begin
      clip.x0    <= x0;
      clip.x1    <= x1;
      clip.y0    <= y0;
      clip.y1    <= y1;
      clip.empty <= (x1 <= x0) || (y1 <= y0);
    end
  end

endmodule

// File: rtl/draw_fillctrl.sv
// Solid rectangle fill into VRAM over an AXI4 write master.
// One burst in flight; bursts never cross BOUNDARY.
module draw_fillctrl
  import draw_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int BOUNDARY  = BOUNDARY_DEF
) (
  input  logic        CLK,
  input  logic        ARST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_BASE,
  input  logic [10:0] REQ_FRM_W,
  input  logic [43:0] REQ_AREA,
  input  logic [23:0] REQ_DPOS,
  input  logic [21:0] REQ_DSIZ,
  input  logic [31:0] REQ_COLOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  fill_state_t state;
  clip_t       clip;

  logic [31:0] base, color, addr;
  logic [10:0] frm_w;
  logic [12:0] y;
  logic [11:0] rem;
  logic [8:0]  beats;
  logic [7:0]  cnt;
  logic        accept;

  logic [23:0] pix;
  logic [31:0] line_addr, nxt_addr, room;
  logic [11:0] nxt_rem;
  logic [8:0]  nxt_beats;

  assign accept       = REQ_VALID && REQ_READY;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_WSTRB  = 4'b1111;

  draw_fill_clip u_clip (
    .clk  (CLK),
    .rst  (ARST),
    .en   (accept),
    .area (REQ_AREA),
    .dpos (REQ_DPOS),
    .dsiz (REQ_DSIZ),
    .clip (clip)
  );

  // next burst: start of a line or continuation after a response
  always_comb begin
    pix       = 24'(y) * 24'(frm_w) + 24'(clip.x0);
    line_addr = base + {6'd0, pix, 2'b00};
    if (state == S_LINE) begin
      nxt_addr = line_addr;
      nxt_rem  = 12'(clip.x1 - clip.x0);
    end else begin
      nxt_addr = addr + {21'd0, beats, 2'b00};
      nxt_rem  = rem - {3'd0, beats};
    end
    room      = (32'(BOUNDARY) - (nxt_addr & 32'(BOUNDARY - 1))) >> 2;
    nxt_beats = 9'(BURST_MAX);
    if ({20'd0, nxt_rem} < 32'(nxt_beats))
      nxt_beats = nxt_rem[8:0];
    if (room < 32'(nxt_beats))
      nxt_beats = 9'(room);
  end

  // fill sequencer with registered handshake outputs
  always_ff @(posedge CLK) begin
    if (ARST) begin
      state         <= S_IDLE;
      REQ_READY     <= 1'b1;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_AWLEN   <= 8'd0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_WDATA   <= 32'd0;
      M_AXI_BREADY  <= 1'b0;
      base          <= 32'd0;
      color         <= 32'd0;
      addr          <= 32'd0;
      frm_w         <= 11'd0;
      y             <= 13'd0;
      rem           <= 12'd0;
      beats         <= 9'd0;
      cnt           <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            base      <= REQ_BASE;
            frm_w     <= REQ_FRM_W;
            color     <= REQ_COLOR;
            REQ_READY <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (clip.empty) begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            y     <= clip.y0;
            state <= S_LINE;
          end
        end
        S_LINE: begin
          addr          <= nxt_addr;
          rem           <= nxt_rem;
          beats         <= nxt_beats;
          M_AXI_AWLEN   <= 8'(nxt_beats - 9'd1);
          M_AXI_AWVALID <= 1'b1;
          state         <= S_AW;
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_WDATA   <= color;
            M_AXI_WLAST   <= (M_AXI_AWLEN == 8'd0);
            cnt           <= 8'd0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (M_AXI_WREADY) begin
            if (M_AXI_WLAST) begin
              M_AXI_WVALID <= 1'b0;
              M_AXI_WLAST  <= 1'b0;
              M_AXI_BREADY <= 1'b1;
              state        <= S_B;
            end else begin
              cnt         <= cnt + 8'd1;
              M_AXI_WLAST <= ((cnt + 8'd1) == M_AXI_AWLEN);
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (nxt_rem != 12'd0) begin
              addr          <= nxt_addr;
              rem           <= nxt_rem;
              beats         <= nxt_beats;
              M_AXI_AWLEN   <= 8'(nxt_beats - 9'd1);
              M_AXI_AWVALID <= 1'b1;
              state         <= S_AW;
            end else if ((y + 13'd1) < clip.y1) begin
              y     <= y + 13'd1;
              state <= S_LINE;
            end else begin
              DONE  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          REQ_READY <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_fillctrl.sv
// Directed bench for draw_fillctrl with an AXI write monitor.
// Expected bursts are worked out by hand from the fill geometry.
module tb_draw_fillctrl;

  logic        CLK = 1'b0;
  logic        ARST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [31:0] REQ_BASE = '0;
  logic [10:0] REQ_FRM_W = '0;
  logic [43:0] REQ_AREA = '0;
  logic [23:0] REQ_DPOS = '0;
  logic [21:0] REQ_DSIZ = '0;
  logic [31:0] REQ_COLOR = '0;
  logic        BUSY, DONE;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY = 1'b1;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID;
  logic        WREADY = 1'b1;
  logic        BVALID = 1'b1;
  logic        BREADY;
  logic        rnd = 1'b0;

  int errors = 0;
  int checks = 0;

  draw_fillctrl dut (
    .CLK           (CLK),
    .ARST          (ARST),
    .REQ_VALID     (REQ_VALID),
    .REQ_READY     (REQ_READY),
    .REQ_BASE      (REQ_BASE),
    .REQ_FRM_W     (REQ_FRM_W),
    .REQ_AREA      (REQ_AREA),
    .REQ_DPOS      (REQ_DPOS),
    .REQ_DSIZ      (REQ_DSIZ),
    .REQ_COLOR     (REQ_COLOR),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .M_AXI_AWADDR  (AWADDR),
    .M_AXI_AWLEN   (AWLEN),
    .M_AXI_AWVALID (AWVALID),
    .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA   (WDATA),
    .M_AXI_WSTRB   (WSTRB),
    .M_AXI_WLAST   (WLAST),
    .M_AXI_WVALID  (WVALID),
    .M_AXI_WREADY  (WREADY),
    .M_AXI_BVALID  (BVALID),
    .M_AXI_BREADY  (BREADY)
  );

  always #5 CLK = ~CLK;

  // slave-side stall generator
  always @(negedge CLK) begin
    if (rnd) begin
      AWREADY = ($urandom_range(0, 2) == 0);
      WREADY  = ($urandom_range(0, 2) != 0);
      BVALID  = ($urandom_range(0, 2) == 0);
    end else begin
      AWREADY = 1'b1;
      WREADY  = 1'b1;
      BVALID  = 1'b1;
    end
  end

  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          beats_n = 0;
  int          done_n = 0;
  int          awv_n = 0;
  int          stab_n = 0;
  int          wlast_n = 0;
  int          legal_n = 0;
  logic [31:0] last_wdata = '0;
  logic        aw_pend = 0, w_pend = 0;
  logic [31:0] p_awaddr, p_wdata;
  logic [7:0]  p_awlen;
  logic        p_wlast;
  int          bi = 0;
  int          cur_len = 0;

  // protocol monitor: handshakes, stability, WLAST placement, legality
  always @(posedge CLK) begin
    if (ARST) begin
      aw_pend = 0;
      w_pend  = 0;
      bi      = 0;
    end else begin
      if (AWVALID) awv_n++;
      if (aw_pend && (AWVALID !== 1'b1 || AWADDR !== p_awaddr ||
                      AWLEN !== p_awlen))
        stab_n++;
      if (w_pend && (WVALID !== 1'b1 || WDATA !== p_wdata ||
                     WLAST !== p_wlast))
        stab_n++;
      aw_pend  = AWVALID && !AWREADY;
      p_awaddr = AWADDR;
      p_awlen  = AWLEN;
      w_pend   = WVALID && !WREADY;
      p_wdata  = WDATA;
      p_wlast  = WLAST;
      if (AWVALID && AWREADY) begin
        aw_addr_q.push_back(AWADDR);
        aw_len_q.push_back(AWLEN);
        cur_len = int'(AWLEN);
        bi      = 0;
        if ((int'(AWADDR % 4096) + (int'(AWLEN) + 1) * 4 > 4096) ||
            AWADDR[1:0] != 2'b00)
          legal_n++;
      end
      if (WVALID && WREADY) begin
        beats_n++;
        last_wdata = WDATA;
        if (WSTRB !== 4'hF) wlast_n++;
        if (WLAST !== (bi == cur_len)) wlast_n++;
        bi++;
      end
      if (DONE) done_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_ready"}, 32'(REQ_READY), 1);
    check({p, "_busy"}, 32'(BUSY), 0);
    check({p, "_done"}, 32'(DONE), 0);
    check({p, "_awvalid"}, 32'(AWVALID), 0);
    check({p, "_wvalid"}, 32'(WVALID), 0);
    check({p, "_wlast"}, 32'(WLAST), 0);
    check({p, "_bready"}, 32'(BREADY), 0);
    check({p, "_awaddr"}, AWADDR, 0);
    check({p, "_awlen"}, 32'(AWLEN), 0);
    check({p, "_wdata"}, WDATA, 0);
    check({p, "_wstrb"}, 32'(WSTRB), 32'hF);
  endtask

  task automatic issue(input logic [31:0] base, input logic [10:0] fw,
                       input logic [43:0] area, input logic [23:0] dpos,
                       input logic [21:0] dsiz, input logic [31:0] color);
    int n = 0;
    @(negedge CLK);
    REQ_BASE  = base;
    REQ_FRM_W = fw;
    REQ_AREA  = area;
    REQ_DPOS  = dpos;
    REQ_DSIZ  = dsiz;
    REQ_COLOR = color;
    REQ_VALID = 1'b1;
    while (!REQ_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_n == d0 && n < 20000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 20000), 1);
    repeat (4) @(negedge CLK);
  endtask

  localparam logic [43:0] FULL = {11'd0, 11'd0, 11'd640, 11'd480};

  int a0, b0, d0, v0, s0, w0, l0, n;

  initial begin
    repeat (3) @(negedge CLK);
    check_reset("rst");
    ARST = 1'b0;
    repeat (2) @(negedge CLK);

    // two 16-pixel lines
    a0 = aw_addr_q.size(); b0 = beats_n; d0 = done_n; w0 = wlast_n;
    issue(32'h1000_0000, 11'd640, FULL, {12'd10, 12'd20},
          {11'd16, 11'd2}, 32'hCAFE_F00D);
    check("t1_busy", 32'(BUSY), 1);
    check("t1_ready", 32'(REQ_READY), 0);
    wait_done("t1", d0);
    check("t1_awn", 32'(aw_addr_q.size() - a0), 2);
    check("t1_aw0", aw_addr_q[a0], 32'h1000_C828);
    check("t1_len0", 32'(aw_len_q[a0]), 15);
    check("t1_aw1", aw_addr_q[a0 + 1], 32'h1000_D228);
    check("t1_len1", 32'(aw_len_q[a0 + 1]), 15);
    check("t1_beats", 32'(beats_n - b0), 32);
    check("t1_done", 32'(done_n - d0), 1);
    check("t1_wdata", last_wdata, 32'hCAFE_F00D);
    check("t1_wlast", 32'(wlast_n - w0), 0);
    check("t1_rdy", 32'(REQ_READY), 1);

    // 600-pixel line split by BURST_MAX
    a0 = aw_addr_q.size(); b0 = beats_n; d0 = done_n;
    issue(32'h2000_0000, 11'd640, FULL, 24'd0, {11'd600, 11'd1},
          32'h1234_5678);
    wait_done("t2", d0);
    check("t2_awn", 32'(aw_addr_q.size() - a0), 3);
    check("t2_aw0", aw_addr_q[a0], 32'h2000_0000);
    check("t2_aw1", aw_addr_q[a0 + 1], 32'h2000_0400);
    check("t2_aw2", aw_addr_q[a0 + 2], 32'h2000_0800);
    check("t2_len0", 32'(aw_len_q[a0]), 255);
    check("t2_len1", 32'(aw_len_q[a0 + 1]), 255);
    check("t2_len2", 32'(aw_len_q[a0 + 2]), 87);
    check("t2_beats", 32'(beats_n - b0), 600);

    // 4 KB boundary split
    a0 = aw_addr_q.size(); d0 = done_n;
    issue(32'h0000_0FF0, 11'd640, FULL, 24'd0, {11'd8, 11'd1}, 32'h1);
    wait_done("t3", d0);
    check("t3_awn", 32'(aw_addr_q.size() - a0), 2);
    check("t3_aw0", aw_addr_q[a0], 32'h0000_0FF0);
    check("t3_len0", 32'(aw_len_q[a0]), 3);
    check("t3_aw1", aw_addr_q[a0 + 1], 32'h0000_1000);
    check("t3_len1", 32'(aw_len_q[a0 + 1]), 3);

    // negative origin clipped to 5x7
    a0 = aw_addr_q.size(); b0 = beats_n; d0 = done_n;
    issue(32'h4000_0000, 11'd640, FULL, {12'hFFB, 12'hFFD},
          {11'd10, 11'd10}, 32'h2);
    wait_done("t4", d0);
    check("t4_awn", 32'(aw_addr_q.size() - a0), 7);
    check("t4_aw0", aw_addr_q[a0], 32'h4000_0000);
    check("t4_len0", 32'(aw_len_q[a0]), 4);
    check("t4_aw6", aw_addr_q[a0 + 6], 32'h4000_3C00);
    check("t4_beats", 32'(beats_n - b0), 35);

    // fully clipped: no address traffic
    a0 = aw_addr_q.size(); d0 = done_n; v0 = awv_n;
    issue(32'h4000_0000, 11'd640, FULL, {12'd700, 12'd0},
          {11'd10, 11'd10}, 32'h3);
    wait_done("t5", d0);
    check("t5_done", 32'(done_n - d0), 1);
    check("t5_awvalid", 32'(awv_n - v0), 0);
    check("t5_awn", 32'(aw_addr_q.size() - a0), 0);

    // random stalls across boundary-split lines
    rnd = 1'b1;
    a0 = aw_addr_q.size(); b0 = beats_n; d0 = done_n;
    s0 = stab_n; w0 = wlast_n; l0 = legal_n;
    issue(32'h0, 11'd640, FULL, {12'd100, 12'd5}, {11'd300, 11'd3},
          32'hA5A5_5A5A);
    wait_done("t6", d0);
    rnd = 1'b0;
    check("t6_beats", 32'(beats_n - b0), 900);
    check("t6_awn", 32'(aw_addr_q.size() - a0), 6);
    check("t6_len2", 32'(aw_len_q[a0 + 2]), 155);
    check("t6_aw3", aw_addr_q[a0 + 3], 32'h0000_4000);
    check("t6_stable", 32'(stab_n - s0), 0);
    check("t6_wlast", 32'(wlast_n - w0), 0);
    check("t6_legal", 32'(legal_n - l0), 0);
    check("t6_done", 32'(done_n - d0), 1);

    // reset in the middle of a data burst
    b0 = beats_n;
    issue(32'h1000_0000, 11'd640, FULL, {12'd10, 12'd20},
          {11'd16, 11'd2}, 32'hCAFE_F00D);
    n = 0;
    while ((beats_n - b0) < 3 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("t7_reach", 32'(n < 200), 1);
    check("t7_inw", 32'(WVALID), 1);
    ARST = 1'b1;
    @(negedge CLK);
    check_reset("t7");
    ARST = 1'b0;
    @(negedge CLK);

    a0 = aw_addr_q.size(); b0 = beats_n; d0 = done_n;
    issue(32'h1000_0000, 11'd640, FULL, {12'd10, 12'd20},
          {11'd16, 11'd2}, 32'h0BAD_BEEF);
    wait_done("t8", d0);
    check("t8_awn", 32'(aw_addr_q.size() - a0), 2);
    check("t8_aw0", aw_addr_q[a0], 32'h1000_C828);
    check("t8_beats", 32'(beats_n - b0), 32);
    check("t8_done", 32'(done_n - d0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_fillctrl.md
DRAW_FILLCTRL -- requirements
Module: draw_fillctrl

Interface
REQ-001 Parameter BURST_MAX, default 256, maximum beats per AXI write burst; power of two, 1..256.
REQ-002 Parameter BOUNDARY, default 4096, byte boundary that no burst crosses; power of two, >= 4*BURST_MAX.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARST  in  1  reset, synchronous, active-high.
REQ-005 REQ_VALID  in  1  fill command valid.
REQ-006 REQ_READY  out  1  block accepts command.
REQ-007 REQ_BASE  in  32  VRAM base byte address.
REQ-008 REQ_FRM_W  in  11  frame width in pixels (line stride).
REQ-009 REQ_AREA  in  44  clip area {posx[10:0], posy[10:0], sizx[10:0], sizy[10:0]}.
REQ-010 REQ_DPOS  in  24  signed destination origin {x[11:0], y[11:0]}.
REQ-011 REQ_DSIZ  in  22  destination size {x[10:0], y[10:0]}.
REQ-012 REQ_COLOR  in  32  fill pixel value.
REQ-013 BUSY  out  1  command in progress.
REQ-014 DONE  out  1  one-cycle pulse at command completion.
REQ-015 M_AXI_AWADDR/AWLEN/AWVALID/AWREADY  out/out/out/in  32/8/1/1  AXI4 write address.
REQ-016 M_AXI_WDATA/WSTRB/WLAST/WVALID/WREADY  out/out/out/out/in  32/4/1/1/1  AXI4 write data.
REQ-017 M_AXI_BVALID/BREADY  in/out  1/1  AXI4 write response.

Function
REQ-018 Command accepted on REQ_VALID && REQ_READY; REQ_READY = 1 only in S_IDLE; all REQ_* fields registered at acceptance.
REQ-019 States: S_IDLE, S_CLIP, S_LINE, S_AW, S_W, S_B, S_DONE; BUSY = (state != S_IDLE).
REQ-020 S_CLIP (1 cycle): 13-bit signed; x0 = max(dposx, areax), x1 = min(dposx+dsizx, areax+sizx), likewise y0/y1; x1<=x0 or y1<=y0 -> S_DONE, no AXI traffic.
REQ-021 S_LINE: line address = base + ((y*frm_w + x0) << 2), 32-bit wrap; remaining = x1-x0.
REQ-022 Burst beats = min(remaining, BURST_MAX, (BOUNDARY - addr mod BOUNDARY)/4); AWLEN = beats-1.
REQ-023 S_AW: AWVALID=1, AWADDR/AWLEN stable until AWREADY; same-cycle AWREADY -> S_W next cycle.
REQ-024 S_W: WVALID=1, WDATA=color, WSTRB=4'b1111; one beat per cycle while WREADY=1, no bubbles; WLAST=1 exactly on beat AWLEN; payload held while WREADY=0.
REQ-025 Accepted WLAST -> WVALID=0 next cycle, S_B.
REQ-026 S_B: BREADY=1; on BVALID: addr += beats*4, remaining -= beats; remaining>0 -> S_AW; else y+1<y1 -> S_LINE (y+1); else S_DONE.
REQ-027 Exactly one burst outstanding; AW never precedes previous B.
REQ-028 S_DONE: DONE=1 for one cycle, then S_IDLE; REQ_READY=1 in the cycle after DONE.
REQ-029 Line of 1 pixel -> AWLEN=0, WLAST on first beat.
REQ-030 Line of 2048 pixels with BURST_MAX=256 -> >=8 bursts, each legal per REQ-022.

Reset
REQ-031 ARST high at a clock edge: state=S_IDLE, REQ_READY=1, BUSY=0, DONE=0, AWVALID=0, WVALID=0, WLAST=0, BREADY=0, AWADDR=0, AWLEN=0, WDATA=0, WSTRB=4'b1111, internal counters 0.
REQ-032 ARST mid-burst aborts immediately without completing the burst; the system resets the interconnect concurrently.

Structure
REQ-033 Package draw_pkg holds state enum fill_state_t, default BURST_MAX/BOUNDARY constants, pixel-width constant (4 bytes).
REQ-034 Clip arithmetic in sub-module draw_fill_clip (registered output, 1-cycle latency), instantiated once.

Verification
REQ-035 base=0x1000_0000, frm_w=640, area full 640x480, dpos=(10,20), dsiz=(16,2), AWREADY/WREADY/BVALID always 1 -> AW 0x1000_C828 len 15, AW 0x1000_D228 len 15, 32 beats, DONE once.
REQ-036 BURST_MAX=256, dpos=(0,0), dsiz=(600,1), frm_w=640 -> AWLEN 255,255,87; addr 0x..000,0x..400,0x..800.
REQ-037 base=0x0000_0FF0, dsiz=(8,1) -> bursts len 3 @0xFF0 and len 3 @0x1000 (4 KB split).
REQ-038 dpos=(-5,-3), dsiz=(10,10), area=(0,0,640,480) -> clipped 5x7 at (0,0); dpos=(700,0) -> DONE with no AWVALID.
REQ-039 Random AWREADY/WREADY/BVALID stalls -> payloads stable while stalled, WLAST only on final beat, beat count = clipped area.
REQ-040 ARST asserted during S_W beat 3 -> next cycle all outputs at REQ-031 values; new command completes normally.
